// File: rtl/mm_io_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mm_io_pkg
// Purpose  : Shared constants for the memory-mapped keypad port: bus
//            addresses, key codes, status codes, key-latch state type and
//            the press-vector to key-code encoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package mm_io_pkg;

   localparam int NUM_BTNS = 6;

   // Data-memory byte addresses decoded by the port
   localparam logic [7:0] C_ADDR_KEY    = 8'hF6;
   localparam logic [7:0] C_ADDR_PEND   = 8'hF7;
   localparam logic [7:0] C_ADDR_STATUS = 8'hFE;
   localparam logic [7:0] C_ADDR_LED    = 8'hFF;

   // Key codes seen by software at C_ADDR_KEY
   localparam logic [7:0] C_KEY_NONE   = 8'd0;
   localparam logic [7:0] C_KEY_FLAG   = 8'd1;
   localparam logic [7:0] C_KEY_REVEAL = 8'd2;
   localparam logic [7:0] C_KEY_UP     = 8'd4;
   localparam logic [7:0] C_KEY_RIGHT  = 8'd5;
   localparam logic [7:0] C_KEY_DOWN   = 8'd6;
   localparam logic [7:0] C_KEY_LEFT   = 8'd7;

   // Game status values written by software to C_ADDR_STATUS
   localparam logic [7:0] C_STATUS_WON  = 8'd2;
   localparam logic [7:0] C_STATUS_DEAD = 8'd6;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } key_state_t;

   // Button index (BTN bit) to key code
   function automatic logic [7:0] btn_code(input int idx);
      logic [7:0] code;
      case (idx)
         0:       code = C_KEY_REVEAL;
         1:       code = C_KEY_FLAG;
         2:       code = C_KEY_UP;
         3:       code = C_KEY_RIGHT;
         4:       code = C_KEY_DOWN;
         5:       code = C_KEY_LEFT;
         default: code = C_KEY_NONE;
      endcase
      return code;
   endfunction

   // Lowest set index wins; scanning downward lets the lowest overwrite last
   function automatic logic [7:0] press_code(input logic [NUM_BTNS-1:0] ev);
      logic [7:0] code;
      code = C_KEY_NONE;
      for (int i = NUM_BTNS - 1; i >= 0; i--) begin
         if (ev[i]) code = btn_code(i);
      end
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_keypad_port_if.sv
`default_nettype none
//==============================================================================
// Module   : mmio_keypad_port_if
// Purpose  : CPU data-memory byte bus between the core and the keypad port.
// Ports    : ADDR  - byte address          (master -> slave)
//            WDATA - store data (SB)       (master -> slave)
//            WE    - one-cycle store strobe (master -> slave)
//            RDATA - load data (LB)        (slave -> master)
//            HIT   - address belongs here  (slave -> master)
// Revision : 1.0 - initial release
//==============================================================================
interface mmio_keypad_port_if;
   logic [7:0] ADDR;
   logic [7:0] WDATA;
   logic       WE;
   logic [7:0] RDATA;
   logic       HIT;

   modport master (
      output ADDR,
      output WDATA,
      output WE,
      input  RDATA,
      input  HIT
   );

   modport slave (
      input  ADDR,
      input  WDATA,
      input  WE,
      output RDATA,
      output HIT
   );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
//==============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchronizer plus counter debouncer for one raw button.
//            Emits a one-cycle press pulse on the cycle the debounced level
//            is about to go 0->1, so the consumer registers it on the same
//            edge the level changes. Releases produce nothing.
// Ports    : CLK, RESET (sync, active-high)
//            btn_async - raw asynchronous button input
//            press     - press event (combinational from registered state)
// Revision : 1.0 - initial release
//==============================================================================
module btn_debounce #(
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
) (
   input  wire logic CLK,
   input  wire logic RESET,
   input  wire logic btn_async,
   output logic      press
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

   logic w_differ;
   logic w_toggle;

   assign w_differ = (r_sync2 != r_level);
   // DB_CYCLES consecutive disagreeing samples flip the level
   assign w_toggle = w_differ && (r_cnt == C_CNT_LAST);
   assign press    = w_toggle && !r_level;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= btn_async;
         r_sync2 <= r_sync1;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (w_toggle) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mmio_keypad_port.sv
`default_nettype none
//==============================================================================
// Module   : mmio_keypad_port
// Purpose  : Memory-mapped keypad / LED / status port for the game CPU.
//            Debounces six buttons, latches one key code until software
//            acknowledges it, and holds LED and STATUS registers.
// Ports    : CLK, RESET (sync, active-high)
//            bus     - CPU byte bus (slave): ADDR, WDATA, WE, RDATA, HIT
//            BTN     - raw buttons: 0 reveal,1 flag,2 up,3 right,4 down,5 left
//            LED     - last byte stored to 0xFF
//            STATUS  - last byte stored to 0xFE
//            REFRESH - one-cycle pulse after a nonzero store to 0xF7
//            Map: 0xF6 key code (R), 0xF7 pending flag (R) / ack-refresh (W),
//                 0xFE status (R/W), 0xFF LED (R/W)
// Revision : 1.0 - initial release
//==============================================================================
module mmio_keypad_port
   import mm_io_pkg::*;
#(
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 20
) (
   input  wire logic              CLK,
   input  wire logic              RESET,
   mmio_keypad_port_if.slave      bus,
   input  wire logic [NUM_BTNS-1:0] BTN,
   output logic [7:0]             LED,
   output logic [7:0]             STATUS,
   output logic                   REFRESH
);

   logic [NUM_BTNS-1:0] w_press;
   logic                w_any_press;
   logic [7:0]          w_code;
   logic                w_we_pend;
   logic                w_ack;
   logic                w_refresh_req;

   key_state_t r_state;
   key_state_t w_state_nxt;
   logic [7:0] r_key;
   logic [7:0] w_key_nxt;
   logic       w_pend;

   logic [7:0] r_led;
   logic [7:0] r_status;
   logic       r_refresh;

   // One synchronizer+debouncer per button
   generate
      for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
         btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
         ) u_debounce (
            .CLK       (CLK),
            .RESET     (RESET),
            .btn_async (BTN[gi]),
            .press     (w_press[gi])
         );
      end
   endgenerate

   assign w_any_press   = |w_press;
   assign w_code        = press_code(w_press);

   // A store of zero to 0xF7 acknowledges the key; nonzero requests a refresh
   assign w_we_pend     = bus.WE && (bus.ADDR == C_ADDR_PEND);
   assign w_ack         = w_we_pend && (bus.WDATA == 8'h00);
   assign w_refresh_req = w_we_pend && (bus.WDATA != 8'h00);

   //---------------------------------------------------------------------------
   // Key-latch FSM
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_key   <= C_KEY_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      case (r_state)
         ST_IDLE: begin
            if (w_any_press) begin
               w_state_nxt = ST_HELD;
               w_key_nxt   = w_code;
            end
         end
         ST_HELD: begin
            // A fresh press coinciding with the ack replaces the old key;
            // a press without an ack is dropped.
            if (w_ack && w_any_press) begin
               w_key_nxt = w_code;
            end else if (w_ack) begin
               w_state_nxt = ST_IDLE;
               w_key_nxt   = C_KEY_NONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_key_nxt   = C_KEY_NONE;
         end
      endcase
   end

   assign w_pend = (r_state == ST_HELD);

   //---------------------------------------------------------------------------
   // Output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_led     <= 8'h00;
         r_status  <= 8'h00;
         r_refresh <= 1'b0;
      end else begin
         r_refresh <= w_refresh_req;
         if (bus.WE && (bus.ADDR == C_ADDR_LED))    r_led    <= bus.WDATA;
         if (bus.WE && (bus.ADDR == C_ADDR_STATUS)) r_status <= bus.WDATA;
      end
   end

   assign LED     = r_led;
   assign STATUS  = r_status;
   assign REFRESH = r_refresh;

   //---------------------------------------------------------------------------
   // Load path
   //---------------------------------------------------------------------------
   always_comb begin
      bus.RDATA = 8'h00;
      bus.HIT   = 1'b0;
      case (bus.ADDR)
         C_ADDR_KEY: begin
            bus.RDATA = r_key;
            bus.HIT   = 1'b1;
         end
         C_ADDR_PEND: begin
            bus.RDATA = {7'b0, w_pend};
            bus.HIT   = 1'b1;
         end
         C_ADDR_STATUS: begin
            bus.RDATA = r_status;
            bus.HIT   = 1'b1;
         end
         C_ADDR_LED: begin
            bus.RDATA = r_led;
            bus.HIT   = 1'b1;
         end
         default: begin
            bus.RDATA = 8'h00;
            bus.HIT   = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
